// File: rtl/div_sequencer_if.sv
// Start/done handshake bundle between an ALU DIV issuer and the sequential divider.
// The issuer uses the master view; the divider uses the slave view.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle signed integer divider: one non-restoring step per clock.
// Quotient goes to LO and remainder to HI. Quotient truncates toward zero and
// the remainder takes the sign of the dividend. A zero divisor short-cuts to
// DONE with quotient all ones and remainder equal to the dividend.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    div_sequencer_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIXUP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   m_reg;
    logic [CW-1:0]    count;
    logic             sq;
    logic             sr;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div0_r;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] rem_signed;

    // A W-bit negate of -2^(W-1) yields 2^(W-1), which is the correct unsigned
    // magnitude, so W bits suffice; the divisor is zero-extended to W+1 for A.
    assign dvd_mag = dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
    assign dvs_mag = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;

    // One non-restoring step: the sign of the partial remainder before the
    // shift picks add or subtract, and the new sign gives the quotient bit.
    assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign a_step  = a_reg[WIDTH] ? (a_shift + m_reg) : (a_shift - m_reg);
    assign q_step  = {q_reg[WIDTH-2:0], ~a_step[WIDTH]};

    // A negative final partial remainder is restored; only the low W bits can
    // be non-zero afterwards, so the restore is done in W bits.
    assign rem_mag    = a_reg[WIDTH] ? (a_reg[WIDTH-1:0] + m_reg[WIDTH-1:0]) : a_reg[WIDTH-1:0];
    assign quo_signed = sq ? -q_reg : q_reg;
    assign rem_signed = sr ? -rem_mag : rem_mag;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing: IDLE -> SETUP -> ITER x WIDTH -> FIXUP -> DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (dvs_r == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (count == LAST_STEP) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div0_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd_r  <= bus.dividend;
                        dvs_r  <= bus.divisor;
                        div0_r <= 1'b0;
                    end
                end
                SETUP: begin
                    sq    <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
                    sr    <= dvd_r[WIDTH-1];
                    a_reg <= '0;
                    q_reg <= dvd_mag;
                    m_reg <= {1'b0, dvs_mag};
                    count <= '0;
                    if (dvs_r == '0) begin
                        quotient_r  <= '1;
                        remainder_r <= dvd_r;
                        div0_r      <= 1'b1;
                    end
                end
                ITER: begin
                    a_reg <= a_step;
                    q_reg <= q_step;
                    count <= count + CW'(1);
                end
                FIXUP: begin
                    quotient_r  <= quo_signed;
                    remainder_r <= rem_signed;
                    div0_r      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div0_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// operands compared against a plain-arithmetic signed division model.
module tb_div_sequencer;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    div_sequencer_if #(.WIDTH(32)) bus();

    div_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Reference: truncating signed division done in 64-bit arithmetic, with
    // the divide-by-zero convention layered on top.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = 32'(lq);
            r  = 32'(lr);
            z  = 1'b0;
        end
    endfunction

    // Issue one division from idle and wait (bounded) for done. Returns the
    // cycle in which done was seen (edge 0 = acceptance), 100 on timeout,
    // and leaves the bench one cycle past DONE so the divider is idle again.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic z, output int cyc);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        reset        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("[TB] FAIL reset_q got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("[TB] FAIL reset_r got %h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_div0 got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_basic();
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        run_op(32'd100, 32'd7, q, r, z, cyc);
        checks++; if (cyc !== 35) begin errors++; $display("[TB] FAIL basic_latency got %0d want 35", cyc); end
        checks++; if (q !== 32'd14) begin errors++; $display("[TB] FAIL basic_q got %h want %h", q, 32'd14); end
        checks++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL basic_r got %h want %h", r, 32'd2); end
        checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL basic_div0 got %b want 0", z); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_signs();
        logic [31:0] dvd [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] dvs [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] eq  [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
        logic [31:0] er  [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            run_op(dvd[i], dvs[i], q, r, z, cyc);
            checks++; if (q !== eq[i]) begin errors++; $display("[TB] FAIL signs_q[%0d] got %h want %h", i, q, eq[i]); end
            checks++; if (r !== er[i]) begin errors++; $display("[TB] FAIL signs_r[%0d] got %h want %h", i, r, er[i]); end
            checks++; if (cyc !== 35) begin errors++; $display("[TB] FAIL signs_latency[%0d] got %0d want 35", i, cyc); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        run_op(32'h1234_5678, 32'd0, q, r, z, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL div0_latency got %0d want 2", cyc); end
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div0_q got %h want ffffffff", q); end
        checks++; if (r !== 32'h1234_5678) begin errors++; $display("[TB] FAIL div0_r got %h want 12345678", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag got %b want 1", z); end
        // Flag must hold while idle, then clear as soon as the next start is accepted.
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL div0_hold got %b want 1", bus.div_by_zero); end
        bus.dividend = 32'd10;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL div0_clear got %b want 0", bus.div_by_zero); end
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++; if (cyc !== 35) begin errors++; $display("[TB] FAIL div0_next_latency got %0d want 35", cyc); end
        checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd1) begin
            errors++; $display("[TB] FAIL div0_next_result got q=%h r=%h want q=3 r=1", bus.quotient, bus.remainder);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_overflow();
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, cyc);
        checks++; if (q !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_q got %h want 80000000", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL ovf_r got %h want 0", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL ovf_div0 got %b want 0", z); end
        run_op(32'h7FFF_FFFF, 32'd1, q, r, z, cyc);
        checks++; if (q !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL max_q got %h want 7fffffff", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL max_r got %h want 0", r); end
    endtask

    task automatic test_ignored_start();
        logic [31:0] q = 32'd0;
        logic [31:0] r = 32'd0;
        int          cyc;
        int          done_cyc = 0;
        int          extra_done = 0;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        // Scramble operands every cycle and retry start mid-op, in FIXUP and in DONE.
        while (cyc < 40) begin
            if (bus.done === 1'b1) begin
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    q = bus.quotient;
                    r = bus.remainder;
                end else begin
                    extra_done++;
                end
            end
            bus.start    = (cyc == 5 || cyc == 34 || cyc == 35);
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            @(posedge clock); #1;
            cyc++;
        end
        bus.start = 1'b0;
        checks++; if (done_cyc !== 35) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 35", done_cyc); end
        checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++; $display("[TB] FAIL ignore_result got q=%h r=%h want q=e r=2", q, r); end
        checks++; if (extra_done !== 0) begin errors++; $display("[TB] FAIL ignore_extra_done got %0d want 0", extra_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        int          seen_done = 0;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_outputs got q=%h r=%h z=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen_done++;
            @(posedge clock); #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d want 0", seen_done); end
        run_op(32'd9, 32'd3, q, r, z, cyc);
        checks++; if (cyc !== 35) begin errors++; $display("[TB] FAIL abort_next_latency got %0d want 35", cyc); end
        checks++; if (q !== 32'd3 || r !== 32'd0) begin errors++; $display("[TB] FAIL abort_next_result got q=%h r=%h want q=3 r=0", q, r); end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       pick_val = 32'h8000_0000;
            1:       pick_val = 32'hFFFF_FFFF;
            2:       pick_val = 32'h7FFF_FFFF;
            3:       pick_val = 32'($urandom_range(1, 300));
            4:       pick_val = -32'($urandom_range(1, 300));
            default: pick_val = $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          cyc;
        for (int i = 0; i < 60; i++) begin
            a = pick_val();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
            ref_div(a, b, eq, er, ez);
            run_op(a, b, q, r, z, cyc);
            checks++; if (q !== eq || r !== er || z !== ez) begin
                errors++; $display("[TB] FAIL random[%0d] %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b", i, a, b, q, r, z, eq, er, ez);
            end
            checks++; if (cyc !== (ez ? 2 : 35)) begin
                errors++; $display("[TB] FAIL random_latency[%0d] got %0d want %0d", i, cyc, ez ? 2 : 35);
            end
        end
    endtask

    // Run the scenarios in order, then report.
    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
